// File: rtl/fp_adder_param.sv
// fp_adder_param: multi-cycle parametrised FP adder/subtractor.
// sign|biased exp|fraction, hidden 1, RNE, saturate/flush flags.
module fp_adder_param #(
  parameter  int EXP_W = 3,
  parameter  int MAN_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         overflow,
  output logic         underflow
);

  // carry | hidden | fraction | guard | round | sticky
  localparam int MW = MAN_W + 5;
  // one spare bit so exp can exceed the field before saturation
  localparam int EW = EXP_W + 1;
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sg;
  logic             r_diff;
  logic [EW-1:0]    r_exp;
  logic [EXP_W-1:0] r_d;
  logic [MW-1:0]    r_mg;
  logic [MW-1:0]    r_ml;
  logic [W-1:0]     r_sum;
  logic             r_ovf;
  logic             r_unf;

  logic [EXP_W-1:0] w_ea;
  logic [EXP_W-1:0] w_eb;
  logic             w_za;
  logic             w_zb;
  logic [W-2:0]     w_mag_a;
  logic [W-2:0]     w_mag_b;
  logic             w_a_ge;
  logic [EXP_W-1:0] w_d;
  logic [MW-1:0]    w_ma;
  logic [MW-1:0]    w_mb;
  logic             w_far;
  logic [MW-1:0]    w_shr_l;
  logic [MW-1:0]    w_add;
  logic             w_add_z;
  logic             w_need_norm;
  logic [MW-1:0]    w_shl;
  logic [MW-1:0]    w_shr;
  logic             w_uflow;
  logic             w_inc;
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_frac;
  logic [EW-1:0]    w_exp_r;
  logic             w_ovf;

  // operand fields; a zero exponent means the value is zero
  assign w_ea    = r_a[W-2:MAN_W];
  assign w_eb    = r_b[W-2:MAN_W];
  assign w_za    = (w_ea == '0);
  assign w_zb    = (w_eb == '0);
  assign w_mag_a = w_za ? '0 : r_a[W-2:0];
  assign w_mag_b = w_zb ? '0 : r_b[W-2:0];
  assign w_a_ge  = (w_mag_a >= w_mag_b);
  assign w_d     = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_ma    = w_za ? '0 : {2'b01, r_a[MAN_W-1:0], 3'b000};
  assign w_mb    = w_zb ? '0 : {2'b01, r_b[MAN_W-1:0], 3'b000};

  // alignment: far shifts collapse into the sticky bit in one step
  assign w_far   = (32'(r_d) > 32'(MAN_W + 3));
  assign w_shr_l = {1'b0, r_ml[MW-1:2], |r_ml[1:0]};

  // magnitude add or subtract of the ordered operands
  assign w_add       = r_diff ? (r_mg - r_ml) : (r_mg + r_ml);
  assign w_add_z     = (w_add == '0);
  assign w_need_norm = w_add[MW-1] | ~w_add[MW-2];

  // normalisation shifts
  assign w_shl   = {r_mg[MW-2:0], 1'b0};
  assign w_shr   = {1'b0, r_mg[MW-1:2], |r_mg[1:0]};
  assign w_uflow = (r_exp <= EW'(1));

  // round to nearest even on guard/round/sticky
  assign w_inc   = r_mg[2] & (r_mg[1] | r_mg[0] | r_mg[3]);
  assign w_rnd   = {1'b0, r_mg[MW-2:3]} + (MAN_W+2)'(w_inc);
  assign w_frac  = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_exp_r = r_exp + EW'(w_rnd[MAN_W+1]);
  assign w_ovf   = (w_exp_r > EMAX);

  // state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SWAP;
      end
      S_SWAP: begin
        w_next = (w_d == '0) ? S_ADD : S_ALIGN;
      end
      S_ALIGN: begin
        if (w_far || (r_d == EXP_W'(1))) w_next = S_ADD;
      end
      S_ADD: begin
        if (w_add_z)          w_next = S_DONE;
        else if (w_need_norm) w_next = S_NORM;
        else                  w_next = S_ROUND;
      end
      S_NORM: begin
        if (r_mg[MW-1])     w_next = S_ROUND;
        else if (w_uflow)   w_next = S_DONE;
        else if (w_shl[MW-2]) w_next = S_ROUND;
      end
      S_ROUND: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // handshake outputs
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_IDLE:  ready = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  assign sum       = r_sum;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

  // datapath; results land in r_sum on the edge that enters DONE
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sg   <= 1'b0;
      r_diff <= 1'b0;
      r_exp  <= '0;
      r_d    <= '0;
      r_mg   <= '0;
      r_ml   <= '0;
      r_sum  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= {b[W-1] ^ sub, b[W-2:0]};
          end
        end
        S_SWAP: begin
          r_diff <= r_a[W-1] ^ r_b[W-1];
          r_d    <= w_d;
          if (w_a_ge) begin
            r_sg  <= r_a[W-1];
            r_exp <= {1'b0, w_ea};
            r_mg  <= w_ma;
            r_ml  <= w_mb;
          end else begin
            r_sg  <= r_b[W-1];
            r_exp <= {1'b0, w_eb};
            r_mg  <= w_mb;
            r_ml  <= w_ma;
          end
        end
        S_ALIGN: begin
          if (w_far) begin
            r_ml <= {{(MW-1){1'b0}}, |r_ml};
            r_d  <= '0;
          end else begin
            r_ml <= w_shr_l;
            r_d  <= r_d - EXP_W'(1);
          end
        end
        S_ADD: begin
          r_mg <= w_add;
          if (w_add_z) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
          end
        end
        S_NORM: begin
          if (r_mg[MW-1]) begin
            r_mg  <= w_shr;
            r_exp <= r_exp + EW'(1);
          end else if (w_uflow) begin
            r_sum <= {r_sg, {(W-1){1'b0}}};
            r_ovf <= 1'b0;
            r_unf <= 1'b1;
          end else begin
            r_mg  <= w_shl;
            r_exp <= r_exp - EW'(1);
          end
        end
        S_ROUND: begin
          if (w_ovf) begin
            r_sum <= {r_sg, {(W-1){1'b1}}};
          end else begin
            r_sum <= {r_sg, w_exp_r[EXP_W-1:0], w_frac};
          end
          r_ovf <= w_ovf;
          r_unf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_param.sv
// tb_fp_adder_param: scoreboard bench for fp_adder_param.
// Directed vectors, EXP_W=3 / MAN_W=4.
module tb_fp_adder_param;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       done;
  logic [7:0] sum;
  logic       overflow;
  logic       underflow;

  typedef struct {
    int         id;
    logic [7:0] want;
    logic       o;
    logic       u;
    int         lat;
    int         s_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   cyc    = 0;

  fp_adder_param #(.EXP_W(3), .MAN_W(4)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .sub(sub),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .sum(sum),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int id,
                     input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s id=%0d got=0x%0h want=0x%0h",
               nm, id, act, want);
    end
  endtask

  // monitor: pop and compare on every done pulse
  initial forever begin
    @(negedge clk);
    if (clr_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done got=0x%0h want=none", sum);
      end else begin
        me = sb.pop_front();
        chk("sum", me.id, int'(sum), int'(me.want));
        chk("overflow", me.id, int'(overflow), int'(me.o));
        chk("underflow", me.id, int'(underflow), int'(me.u));
        chk("latency", me.id, cyc - me.s_cyc + 2, me.lat);
      end
    end
  end

  task automatic push(input int id, input logic [7:0] w,
                      input logic o, input logic u, input int lat);
    exp_t e;
    e.id    = id;
    e.want  = w;
    e.o     = o;
    e.u     = u;
    e.lat   = lat;
    e.s_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic run_op(input int id, input logic [7:0] ia,
                        input logic [7:0] ib, input logic is,
                        input logic [7:0] w, input logic o,
                        input logic u, input int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    a = ia;
    b = ib;
    sub = is;
    start = 1'b1;
    push(id, w, o, u, lat);
    @(negedge clk);
    start = 1'b0;
    chk("ready_low", id, int'(ready), 0);
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout id=%0d got=no_done want=done", id);
      sb.delete();
    end else begin
      chk("ready_after_done", id, int'(ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int k;
    clr_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 0, int'(ready), 1);
    chk("rst_done", 0, int'(done), 0);
    chk("rst_sum", 0, int'(sum), 0);
    chk("rst_ovf", 0, int'(overflow), 0);
    chk("rst_unf", 0, int'(underflow), 0);
    @(negedge clk);
    clr_n = 1'b1;

    //     id  a      b      sub   sum    ov    un    lat
    run_op(1,  8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 6);
    run_op(2,  8'hB0, 8'h40, 1'b0, 8'h30, 1'b0, 1'b0, 7);
    run_op(3,  8'h38, 8'h38, 1'b1, 8'h00, 1'b0, 1'b0, 4);
    run_op(4,  8'h60, 8'h10, 1'b0, 8'h60, 1'b0, 1'b0, 10);
    run_op(5,  8'h60, 8'h18, 1'b0, 8'h61, 1'b0, 1'b0, 10);
    run_op(6,  8'h6F, 8'h10, 1'b0, 8'h70, 1'b0, 1'b0, 10);
    run_op(7,  8'h3F, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0, 8);
    run_op(8,  8'h61, 8'h60, 1'b1, 8'h20, 1'b0, 1'b0, 9);
    run_op(9,  8'h11, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1, 5);
    run_op(10, 8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0, 6);
    run_op(11, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 6);
    run_op(12, 8'h00, 8'h30, 1'b1, 8'hB0, 1'b0, 1'b0, 8);
    run_op(13, 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 4);
    run_op(14, 8'hB0, 8'h30, 1'b1, 8'hC0, 1'b0, 1'b0, 6);
    run_op(15, 8'h40, 8'h30, 1'b1, 8'h30, 1'b0, 1'b0, 7);

    // start held high, operands changed mid-operation
    @(negedge clk);
    d0 = n_done;
    a = 8'h30;
    b = 8'h30;
    sub = 1'b0;
    start = 1'b1;
    push(20, 8'h40, 1'b0, 1'b0, 6);
    @(negedge clk);
    a = 8'h7F;
    b = 8'h7F;
    sub = 1'b1;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("single_done", 20, n_done - d0, 1);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL held_timeout id=20 got=no_done want=done");
      sb.delete();
    end

    // reset while aligning aborts the operation
    @(negedge clk);
    a = 8'h60;
    b = 8'h10;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_abort_sum", 21, int'(sum), 8'h40);
    chk("pre_abort_ready", 21, int'(ready), 0);
    clr_n = 1'b0;
    #1;
    d0 = n_done;
    chk("abort_ready", 21, int'(ready), 1);
    chk("abort_done", 21, int'(done), 0);
    chk("abort_sum", 21, int'(sum), 0);
    chk("abort_ovf", 21, int'(overflow), 0);
    chk("abort_unf", 21, int'(underflow), 0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", 21, n_done - d0, 0);
    run_op(22, 8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 6);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
